// File: rtl/eneadim_soc.sv
// eneadim_soc: processor-less SoC tile driven by an external register bus.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   ena         slot enable, ignored
//   ui_in       [3:0] addr, [4] we, [5] re
//   uio_in      write data
//   uio_out     registered read data
//   uio_oe      0xFF while read data is driven
//   uo_out      peripheral view selected by CTRL[4:3]
module eneadim_soc #(
  parameter logic [7:0] ID_VALUE = 8'hE5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [3:0]  w_addr;
  logic        w_we;
  logic        w_re;
  logic [15:0] w_wr;
  logic        w_unused;

  logic [7:0] r_gpio;
  logic [4:0] r_ctrl;
  logic [7:0] r_tload;
  logic [7:0] r_tcnt;
  logic [7:0] r_presc;
  logic [7:0] r_duty;
  logic       r_mf;
  logic [7:0] r_scratch;
  logic [7:0] r_pre;
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_uio_out;
  logic [7:0] r_uio_oe;
  logic [7:0] r_uo_out;

  logic       w_ten;
  logic       w_pen;
  logic       w_arl;
  logic [1:0] w_osel;
  logic       w_tick;
  logic       w_match;
  logic       w_mf_set;
  logic       w_mf_clr;
  logic       w_pwm;
  logic [7:0] w_rdata;
  logic [7:0] w_view;

  assign w_addr   = ui_in[3:0];
  assign w_we     = ui_in[4];
  assign w_re     = ui_in[5];
  assign w_unused = &{1'b0, ena, ui_in[7:6]};
  assign w_wr     = w_we ? (16'h0001 << w_addr) : 16'h0000;

  assign w_ten  = r_ctrl[0];
  assign w_pen  = r_ctrl[1];
  assign w_arl  = r_ctrl[2];
  assign w_osel = r_ctrl[4:3];

  assign w_tick   = w_ten && (r_pre == r_presc);
  assign w_match  = (r_tcnt == r_tload);
  assign w_mf_set = w_tick && w_match;
  assign w_mf_clr = w_wr[6] && uio_in[0];
  assign w_pwm    = w_pen && (r_pwm_cnt < r_duty);

  always_comb begin
    w_rdata = 8'h00;
    case (w_addr)
      4'h0:    w_rdata = r_gpio;
      4'h1:    w_rdata = {3'b000, r_ctrl};
      4'h2:    w_rdata = r_tload;
      4'h3:    w_rdata = r_tcnt;
      4'h4:    w_rdata = r_presc;
      4'h5:    w_rdata = r_duty;
      4'h6:    w_rdata = {7'b0, r_mf};
      4'h7:    w_rdata = r_scratch;
      4'h8:    w_rdata = ID_VALUE;
      default: w_rdata = 8'h00;
    endcase
  end

  always_comb begin
    w_view = r_gpio;
    case (w_osel)
      2'd0:    w_view = r_gpio;
      2'd1:    w_view = r_tcnt;
      2'd2:    w_view = {r_gpio[7:2], r_mf, w_pwm};
      default: w_view = ID_VALUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio    <= 8'h00;
      r_ctrl    <= 5'h00;
      r_tload   <= 8'h00;
      r_presc   <= 8'h00;
      r_duty    <= 8'h00;
      r_scratch <= 8'h00;
      r_mf      <= 1'b0;
    end else begin
      if (w_wr[0]) r_gpio    <= uio_in;
      if (w_wr[1]) r_ctrl    <= uio_in[4:0];
      if (w_wr[2]) r_tload   <= uio_in;
      if (w_wr[4]) r_presc   <= uio_in;
      if (w_wr[5]) r_duty    <= uio_in;
      if (w_wr[7]) r_scratch <= uio_in;
      // a match in the same cycle as a clear wins
      r_mf <= w_mf_set | (r_mf & ~w_mf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= 8'h00;
      r_tcnt <= 8'h00;
    end else begin
      if (!w_ten || w_tick) r_pre <= 8'h00;
      else                  r_pre <= r_pre + 8'd1;
      if (w_tick) begin
        // on match without reload the counter parks at TLOAD
        if (w_match) r_tcnt <= w_arl ? 8'h00 : r_tload;
        else         r_tcnt <= r_tcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'h00;
    end else begin
      if (w_pen) r_pwm_cnt <= r_pwm_cnt + 8'd1;
      else       r_pwm_cnt <= 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uio_out <= 8'h00;
      r_uio_oe  <= 8'h00;
      r_uo_out  <= 8'h00;
    end else begin
      if (w_re) r_uio_out <= w_rdata;
      r_uio_oe <= w_re ? 8'hFF : 8'h00;
      r_uo_out <= w_view;
    end
  end

  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;
  assign uo_out  = r_uo_out;

endmodule

// File: tb/tb_eneadim_soc.sv
// Bench for eneadim_soc: directed test plan plus random bus traffic,
// scored against a behavioural register-map model.
module tb_eneadim_soc;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int total = 0;
  int bad = 0;

  eneadim_soc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // expected {uio_out, uio_oe, uo_out} after each rising edge
  logic [23:0] exp_q[$];

  logic [7:0] m_gpio, m_ctrl, m_tload, m_tcnt, m_presc;
  logic [7:0] m_duty, m_scr, m_since, m_pwm;
  logic [7:0] m_out, m_oe, m_uo;
  logic       m_mf;

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_gpio = 0; m_ctrl = 0; m_tload = 0; m_tcnt = 0; m_presc = 0;
    m_duty = 0; m_scr = 0; m_since = 0; m_pwm = 0;
    m_out = 0; m_oe = 0; m_uo = 0; m_mf = 0;
  endtask

  function automatic logic [7:0] m_rd(input logic [3:0] a);
    case (a)
      4'h0: return m_gpio;
      4'h1: return m_ctrl;
      4'h2: return m_tload;
      4'h3: return m_tcnt;
      4'h4: return m_presc;
      4'h5: return m_duty;
      4'h6: return {7'b0, m_mf};
      4'h7: return m_scr;
      4'h8: return 8'hE5;
      default: return 8'h00;
    endcase
  endfunction

  // one clock of the register map, using pre-edge state everywhere
  task automatic model_step(input logic we, input logic re,
                            input logic [3:0] a, input logic [7:0] d);
    logic [7:0] rd, view;
    logic pwm, tick, setmf;
    rd  = m_rd(a);
    pwm = m_ctrl[1] && (m_pwm < m_duty);
    case (m_ctrl[4:3])
      2'd0: view = m_gpio;
      2'd1: view = m_tcnt;
      2'd2: view = {m_gpio[7:2], m_mf, pwm};
      default: view = 8'hE5;
    endcase
    // m_since = clocks elapsed in the current PRESC+1 period
    tick  = m_ctrl[0] && (m_since == m_presc);
    setmf = 1'b0;
    if (!m_ctrl[0] || tick) m_since = 0;
    else m_since = m_since + 8'd1;
    if (tick) begin
      if (m_tcnt == m_tload) begin
        setmf = 1'b1;
        if (m_ctrl[2]) m_tcnt = 0;
      end else begin
        m_tcnt = m_tcnt + 8'd1;
      end
    end
    m_pwm = m_ctrl[1] ? m_pwm + 8'd1 : 8'd0;
    if (we) begin
      case (a)
        4'h0: m_gpio = d;
        4'h1: m_ctrl = d & 8'h1F;
        4'h2: m_tload = d;
        4'h4: m_presc = d;
        4'h5: m_duty = d;
        4'h6: if (d[0]) m_mf = 1'b0;
        4'h7: m_scr = d;
        default: ;
      endcase
    end
    if (setmf) m_mf = 1'b1;
    if (re) m_out = rd;
    m_oe = re ? 8'hFF : 8'h00;
    m_uo = view;
    exp_q.push_back({m_out, m_oe, m_uo});
  endtask

  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("uio_out", uio_out, e[23:16]);
        chk("uio_oe", uio_oe, e[15:8]);
        chk("uo_out", uo_out, e[7:0]);
      end
    end
  end

  task automatic cyc(input logic we, input logic re,
                     input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ui_in  = {2'b00, re, we, a};
    uio_in = d;
    model_step(we, re, a, d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] e,
                        input string n);
    cyc(1'b0, 1'b1, a, 8'h00);
    idle(1);
    chk(n, uio_out, e);
  endtask

  // called at a falling edge
  task automatic release_rst();
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_step(1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_tcnt", dut.r_tcnt, 8'h00);
    chk("ar_mf", {7'b0, dut.r_mf}, 8'h00);
    chk("ar_ctrl", {3'b0, dut.r_ctrl}, 8'h00);
    chk("ar_uo", uo_out, 8'h00);
    chk("ar_oe", uio_oe, 8'h00);
    exp_q.delete();
    model_reset();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic pwm_count(input int exp, input string n);
    int c;
    c = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      c += int'(uo_out[0]);
    end
    total++;
    if (c != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, c, exp);
    end
  endtask

  initial begin
    logic we, re;
    logic [3:0] a;
    logic [7:0] d;
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_out", uio_out, 8'h00);
    release_rst();

    rd_chk(4'h8, 8'hE5, "id");
    idle(1);
    chk("oe_drop", uio_oe, 8'h00);
    chk("uo_zero", uo_out, 8'h00);

    wr(4'h0, 8'hA5);
    wr(4'h7, 8'h3C);
    rd_chk(4'h7, 8'h3C, "scratch");
    chk("gpio_uo", uo_out, 8'hA5);
    wr(4'h3, 8'h55);
    rd_chk(4'h3, 8'h00, "tcnt_ro");

    wr(4'h4, 8'd3);
    wr(4'h2, 8'd2);
    wr(4'h1, 8'h05);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'h3, 8'h00);
    rd_chk(4'h6, 8'h01, "mf_arl");
    wr(4'h1, 8'h00);
    wr(4'h6, 8'h01);
    rd_chk(4'h6, 8'h00, "mf_clr");

    wr(4'h4, 8'd0);
    wr(4'h2, 8'd5);
    wr(4'h1, 8'h01);
    idle(12);
    rd_chk(4'h3, 8'd5, "tcnt_hold");
    rd_chk(4'h6, 8'h01, "mf_hold1");
    rd_chk(4'h6, 8'h01, "mf_hold2");

    wr(4'h1, 8'h05);
    idle(5);
    mid_reset();

    wr(4'h5, 8'd64);
    wr(4'h1, 8'h12);
    idle(2);
    pwm_count(64, "pwm64");
    wr(4'h5, 8'd0);
    idle(2);
    pwm_count(0, "pwm0");
    wr(4'h5, 8'd255);
    idle(2);
    pwm_count(255, "pwm255");

    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 2) == 0);
      re = $urandom_range(0, 1) == 1;
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      if ((a == 4'h2 || a == 4'h4) && $urandom_range(0, 1) == 1)
        d = d & 8'h07;
      if (a == 4'h6 && we && $urandom_range(0, 3) != 0)
        we = 1'b0;
      cyc(we, re, a, d);
      if ($urandom_range(0, 599) == 0) mid_reset();
    end

    idle(1);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
